// File: rtl/io_clk_reconfig_if.sv
// DRP bus between the reconfiguration controller (master) and an MMCM DRP port (slave).
interface io_clk_reconfig_if;
   logic [6:0]  drp_daddr;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_den;
   logic        drp_dwe;
   logic        drp_drdy;

   modport master (
      output drp_daddr, drp_di, drp_den, drp_dwe,
      input  drp_do, drp_drdy
   );

   modport slave (
      input  drp_daddr, drp_di, drp_den, drp_dwe,
      output drp_do, drp_drdy
   );
endinterface

// File: rtl/io_clk_reconfig.sv
// MMCM CLKOUT0 divide reconfiguration over DRP (read-modify-write of ClkReg1/ClkReg2).
// Define IO_CLK_RECONFIG_READBACK_EN to verify each written register by re-reading it.
module io_clk_reconfig #(
   parameter logic [6:0]  CLKREG1_ADDR = 7'h08,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req,
   input  logic [6:0]               divide,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mmcm_rst,
   input  logic                     mmcm_locked,
   io_clk_reconfig_if.master        drp
);

   typedef enum logic [3:0] {
      STARTUP, IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK, DONE
   } state_t;

   localparam logic [31:0] DRP_WAIT_MAX = 32'd255;

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic [6:0]  div_q, div_d;
   logic [6:0]  daddr_q, daddr_d;
   logic [15:0] di_q, di_d;
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        rst_q, rst_d;
   logic        boot_q, boot_d;
   logic        lock_meta_q, lock_sync_q;
   logic        chk_q, chk_d;

   logic        div_one;
   logic [5:0]  hi_cnt, lo_cnt;
   logic [15:0] word1, word2;
   logic        advance, abort;

   // HIGH = divide>>1 and LOW = divide-HIGH = HIGH + divide[0]; divide==1 uses NO_COUNT
   assign div_one = (div_q == 7'd1);
   assign hi_cnt  = div_one ? 6'd1 : div_q[6:1];
   assign lo_cnt  = div_one ? 6'd1 : div_q[6:1] + {5'd0, div_q[0]};
   assign word1   = {drp.drp_do[15:12], hi_cnt, lo_cnt};
   assign word2   = {drp.drp_do[15:8], div_q[0] & ~div_one, div_one, drp.drp_do[5:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= mmcm_locked;
         lock_sync_q <= lock_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STARTUP;
         sel_q   <= 1'b0;
         div_q   <= '0;
         daddr_q <= '0;
         di_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rst_q   <= 1'b1;
         boot_q  <= 1'b0;
         chk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         div_q   <= div_d;
         daddr_q <= daddr_d;
         di_q    <= di_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rst_q   <= rst_d;
         boot_q  <= boot_d;
         chk_q   <= chk_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      div_d       = div_q;
      daddr_d     = daddr_q;
      di_d        = di_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rst_d       = rst_q;
      boot_d      = boot_q;
      chk_d       = chk_q;
      advance     = 1'b0;
      abort       = 1'b0;
      drp.drp_den = 1'b0;
      drp.drp_dwe = 1'b0;

      case (state_q)
         STARTUP: begin
            rst_d   = 1'b0;
            cnt_d   = '0;
            boot_d  = 1'b1;
            state_d = WAIT_LOCK;
         end
         IDLE: begin
            if (req) begin
               if (divide == 7'd0 || divide == 7'h7f) begin
                  err_d = 1'b1;
               end else begin
                  err_d   = 1'b0;
                  div_d   = divide;
                  rst_d   = 1'b1;
                  state_d = ASSERT_RST;
               end
            end
         end
         ASSERT_RST: begin
            sel_d   = 1'b0;
            chk_d   = 1'b0;
            daddr_d = CLKREG1_ADDR;
            state_d = RD;
         end
         RD: begin
            drp.drp_den = 1'b1;
            cnt_d       = '0;
            state_d     = RD_WAIT;
         end
         RD_WAIT: begin
            if (drp.drp_drdy) begin
`ifdef IO_CLK_RECONFIG_READBACK_EN
               if (chk_q) begin
                  if (drp.drp_do != di_q) begin
                     abort = 1'b1;
                  end else begin
                     chk_d   = 1'b0;
                     advance = 1'b1;
                  end
               end else begin
                  di_d    = sel_q ? word2 : word1;
                  state_d = WR;
               end
`else
               di_d    = sel_q ? word2 : word1;
               state_d = WR;
`endif
            end else if (cnt_q == DRP_WAIT_MAX) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         WR: begin
            drp.drp_den = 1'b1;
            drp.drp_dwe = 1'b1;
            cnt_d       = '0;
            state_d     = WR_WAIT;
         end
         WR_WAIT: begin
            if (drp.drp_drdy) begin
`ifdef IO_CLK_RECONFIG_READBACK_EN
               chk_d   = 1'b1;
               state_d = RD;
`else
               advance = 1'b1;
`endif
            end else if (cnt_q == DRP_WAIT_MAX) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RELEASE: begin
            rst_d   = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_sync_q) begin
               boot_d  = 1'b0;
               state_d = boot_q ? IDLE : DONE;
            end else if (cnt_q == LOCK_TIMEOUT) begin
               err_d   = 1'b1;
               boot_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Shared exits of the two wait states: move to ClkReg2 / release, or bail out
      if (advance) begin
         if (!sel_q) begin
            sel_d   = 1'b1;
            daddr_d = CLKREG1_ADDR + 7'd1;
            state_d = RD;
         end else begin
            state_d = RELEASE;
         end
      end
      if (abort) begin
         err_d   = 1'b1;
         rst_d   = 1'b0;
         state_d = IDLE;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign err           = err_q;
   assign mmcm_rst      = rst_q;
   assign drp.drp_daddr = daddr_q;
   assign drp.drp_di    = di_q;

endmodule

// File: tb/tb_io_clk_reconfig.sv
// Directed bench for io_clk_reconfig with a behavioural MMCM DRP/lock model.
module tb_io_clk_reconfig;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req = 1'b0;
   logic [6:0] divide = '0;
   logic       busy, done, err, mmcm_rst;
   logic       mmcm_locked = 1'b0;

   io_clk_reconfig_if drp ();

   io_clk_reconfig #(.CLKREG1_ADDR(7'h08), .LOCK_TIMEOUT(40)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .divide(divide),
      .busy(busy), .done(done), .err(err), .mmcm_rst(mmcm_rst),
      .mmcm_locked(mmcm_locked), .drp(drp.master)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nfail = 0;

   // DRP slave model: fixed latency, registers 0x08/0x09 only
   logic        drdy_en = 1'b1;
   int          lat = 3;
   logic [15:0] reg1_m = 16'hF000, reg2_m = 16'h0000;
   int          pend = 0, pcnt = 0, overlap = 0, nreads = 0;
   logic [6:0]  paddr = '0;
   logic [6:0]  wa_q[$];
   logic [15:0] wd_q[$];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend = 0;
         drp.drp_drdy <= 1'b0;
      end else begin
         drp.drp_drdy <= 1'b0;
         if (drp.drp_den) begin
            if (pend != 0) overlap++;
            pend  = drdy_en ? 1 : 0;
            pcnt  = lat;
            paddr = drp.drp_daddr;
            if (drp.drp_dwe) begin
               wa_q.push_back(drp.drp_daddr);
               wd_q.push_back(drp.drp_di);
               if (drp.drp_daddr == 7'h08) reg1_m = drp.drp_di;
               if (drp.drp_daddr == 7'h09) reg2_m = drp.drp_di;
            end else begin
               nreads++;
            end
         end else if (pend != 0) begin
            if (pcnt <= 1) begin
               pend = 0;
               drp.drp_drdy <= 1'b1;
               drp.drp_do   <= (paddr == 7'h08) ? reg1_m : (paddr == 7'h09) ? reg2_m : 16'h0000;
            end else begin
               pcnt--;
            end
         end
      end
   end

   // Lock model: LOCKED rises about 10 cycles after MMCM reset release
   logic lock_en = 1'b1;
   int   lcnt = 0;
   always @(negedge clk) begin
      if (mmcm_rst || !lock_en) begin
         lcnt = 0;
         mmcm_locked <= 1'b0;
      end else if (lcnt < 10) begin
         lcnt++;
      end else begin
         mmcm_locked <= 1'b1;
      end
   end

   int   ndone = 0, dbl = 0;
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (done) ndone++;
      if (done && done_prev) dbl++;
      done_prev = done;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse(input logic [6:0] d);
      @(negedge clk);
      req    = 1'b1;
      divide = d;
      @(negedge clk);
      req    = 1'b0;
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [6:0] a, input logic [15:0] d);
      logic [6:0]  oa;
      logic [15:0] od;
      oa = (idx < wa_q.size()) ? wa_q[idx] : 7'h7f;
      od = (idx < wd_q.size()) ? wd_q[idx] : 16'hxxxx;
      check({tag, "_addr"}, {25'd0, oa}, {25'd0, a});
      check({tag, "_data"}, {16'd0, od}, {16'd0, d});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, d0, n;
      logic [15:0] tmp;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_den", {31'd0, drp.drp_den}, 32'd0);
      check("rst_dwe", {31'd0, drp.drp_dwe}, 32'd0);
      check("rst_daddr", {25'd0, drp.drp_daddr}, 32'd0);
      check("rst_di", {16'd0, drp.drp_di}, 32'd0);

      // Startup: MMCM reset released one cycle after rst_n, idle once locked
      rst_n = 1'b1;
      @(negedge clk);
      check("boot_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
      check("boot_busy", {31'd0, busy}, 32'd1);
      wait_idle("boot", 40);
      check("boot_no_done", ndone, 0);
      check("boot_err", {31'd0, err}, 32'd0);

      // divide=3 from ClkReg1=F000 / ClkReg2=0000, with an ignored req mid-flight
      w0 = wa_q.size(); r0 = nreads; d0 = ndone;
      pulse(7'd3);
      check("div3_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
      check("div3_busy", {31'd0, busy}, 32'd1);
      repeat (3) @(negedge clk);
      req = 1'b1; divide = 7'd7;
      @(negedge clk);
      req = 1'b0;
      wait_idle("div3", 300);
      check("div3_nwr", wa_q.size() - w0, 2);
      check("div3_nrd", nreads - r0, 2);
      check_wr("div3_w1", w0, 7'h08, 16'hF042);
      check_wr("div3_w2", w0 + 1, 7'h09, 16'h0080);
      check("div3_done", ndone - d0, 1);
      check("div3_err", {31'd0, err}, 32'd0);
      check("div3_mmcm_rst_end", {31'd0, mmcm_rst}, 32'd0);

      // divide=1: HIGH=LOW=1, NO_COUNT=1, EDGE=0
      w0 = wa_q.size(); d0 = ndone;
      pulse(7'd1);
      wait_idle("div1", 300);
      tmp = (w0 < wd_q.size()) ? wd_q[w0] : 16'hxxxx;
      check("div1_reg1_low12", {20'd0, tmp[11:0]}, 32'h041);
      tmp = (w0 + 1 < wd_q.size()) ? wd_q[w0 + 1] : 16'hxxxx;
      check("div1_reg2_b76", {30'd0, tmp[7:6]}, 32'd1);
      check_wr("div1_w1", w0, 7'h08, 16'hF041);
      check_wr("div1_w2", w0 + 1, 7'h09, 16'h0040);
      check("div1_done", ndone - d0, 1);

      // Illegal divides: error, no DRP access, MMCM untouched
      w0 = wa_q.size(); r0 = nreads;
      pulse(7'd0);
      check("div0_err", {31'd0, err}, 32'd1);
      check("div0_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      check("div0_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
      check("div0_nrd", nreads - r0, 0);
      pulse(7'h7f);
      check("div127_err", {31'd0, err}, 32'd1);
      check("div127_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("div127_nrd", nreads - r0, 0);
      check("div127_nwr", wa_q.size() - w0, 0);

      // divide=5 clears the sticky error
      w0 = wa_q.size(); d0 = ndone;
      pulse(7'd5);
      check("div5_err_clr", {31'd0, err}, 32'd0);
      wait_idle("div5", 300);
      check_wr("div5_w1", w0, 7'h08, 16'hF083);
      check_wr("div5_w2", w0 + 1, 7'h09, 16'h0080);
      check("div5_done", ndone - d0, 1);

      // Lock never returns: timeout error, no done
      lock_en = 1'b0;
      w0 = wa_q.size(); d0 = ndone;
      pulse(7'd4);
      wait_idle("tmo", 400);
      check("tmo_err", {31'd0, err}, 32'd1);
      check("tmo_done", ndone - d0, 0);
      check("tmo_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
      check_wr("tmo_w1", w0, 7'h08, 16'hF082);
      check_wr("tmo_w2", w0 + 1, 7'h09, 16'h0000);
      lock_en = 1'b1;
      repeat (20) @(negedge clk);

      // DRP never answers: abort after 255 waiting cycles
      drdy_en = 1'b0;
      w0 = wa_q.size(); d0 = ndone;
      pulse(7'd6);
      check("hang_err_clr", {31'd0, err}, 32'd0);
      n = 0;
      while (busy && n < 250) begin
         @(negedge clk);
         n++;
      end
      check("hang_still_busy", {31'd0, busy}, 32'd1);
      wait_idle("hang", 200);
      check("hang_err", {31'd0, err}, 32'd1);
      check("hang_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
      check("hang_nwr", wa_q.size() - w0, 0);
      check("hang_done", ndone - d0, 0);
      drdy_en = 1'b1;
      repeat (20) @(negedge clk);

      // Reset asserted while a write is outstanding
      lat = 20;
      d0 = ndone;
      pulse(7'd2);
      n = 0;
      while (!(drp.drp_den && drp.drp_dwe) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rstmid_saw_write", {31'd0, drp.drp_den & drp.drp_dwe}, 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
      check("rstmid_den", {31'd0, drp.drp_den}, 32'd0);
      check("rstmid_dwe", {31'd0, drp.drp_dwe}, 32'd0);
      check("rstmid_busy", {31'd0, busy}, 32'd1);
      check("rstmid_daddr", {25'd0, drp.drp_daddr}, 32'd0);
      check("rstmid_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lat = 3;
      wait_idle("rstmid_boot", 60);
      check("rstmid_no_done", ndone - d0, 0);
      check("rstmid_err", {31'd0, err}, 32'd0);

      check("den_overlap", overlap, 0);
      check("done_width", dbl, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
